// File: rtl/motor_arm_sequencer.sv
// Motor arm/disarm sequencer: synchronizes arm and IMU flags, times arm hold and IMU loss in ms ticks,
// and gates the four mixer rates. Define ARM_SOFT_START_EN to ramp-limit rates after arming.
module motor_arm_sequencer #(
  parameter int                RATE_W      = 16,
  parameter int                CLK_PER_MS  = 38000,
  parameter int                ARM_HOLD_MS = 1000,
  parameter logic [7:0]        THR_ARM_MAX = 8'd10,
  parameter int                IMU_LOSS_MS = 20,
  parameter logic [RATE_W-1:0] RAMP_STEP   = 16'h0100
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              arm_switch,
  input  logic              imu_good,
  input  logic [7:0]        throttle_val,
  input  logic [RATE_W-1:0] motor_1_rate_in,
  input  logic [RATE_W-1:0] motor_2_rate_in,
  input  logic [RATE_W-1:0] motor_3_rate_in,
  input  logic [RATE_W-1:0] motor_4_rate_in,
  output logic [RATE_W-1:0] motor_1_rate_out,
  output logic [RATE_W-1:0] motor_2_rate_out,
  output logic [RATE_W-1:0] motor_3_rate_out,
  output logic [RATE_W-1:0] motor_4_rate_out,
  output logic              armed,
  output logic              fault,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam int TICK_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int HOLD_W = $clog2(ARM_HOLD_MS + 1);
  localparam int LOSS_W = $clog2(IMU_LOSS_MS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD_MS);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(IMU_LOSS_MS);

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [HOLD_W-1:0]   hold_reg, hold_next, hold_inc;
  logic [LOSS_W-1:0]   loss_reg, loss_next, loss_inc;
  logic                seen_low_reg, seen_low_next;
  logic                sw_meta_reg, sw_s, imu_meta_reg, imu_s;
  logic [1:0]          sync_fill_reg;
  logic                ms_tick, hold_ok, arm_cond;
  logic [RATE_W-1:0]   rate_in [4];
  logic [RATE_W-1:0]   rate_out_reg [4];
  logic [RATE_W-1:0]   rate_out_next [4];

  assign ms_tick  = (tick_cnt_reg == TICK_LAST);
  assign hold_ok  = sw_s && imu_s && (throttle_val <= THR_ARM_MAX);
  assign arm_cond = hold_ok && seen_low_reg;
  assign hold_inc = hold_reg + HOLD_W'(1);
  assign loss_inc = loss_reg + LOSS_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      sw_meta_reg   <= 1'b0;
      sw_s          <= 1'b0;
      imu_meta_reg  <= 1'b0;
      imu_s         <= 1'b0;
      sync_fill_reg <= 2'b00;
      tick_cnt_reg  <= '0;
    end else begin
      sw_meta_reg   <= arm_switch;
      sw_s          <= sw_meta_reg;
      imu_meta_reg  <= imu_good;
      imu_s         <= imu_meta_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
      tick_cnt_reg  <= ms_tick ? '0 : tick_cnt_reg + TICK_W'(1);
    end
  end

`ifdef ARM_SOFT_START_EN
  logic [RATE_W-1:0] ramp_limit_reg, ramp_limit_next, ramp_sat;
  logic [RATE_W:0]   ramp_sum;
  assign ramp_sum = {1'b0, ramp_limit_reg} + {1'b0, RAMP_STEP};
  assign ramp_sat = ramp_sum[RATE_W] ? '1 : ramp_sum[RATE_W-1:0];
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
`endif

  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    loss_next     = loss_reg;
    seen_low_next = seen_low_reg;
`ifdef ARM_SOFT_START_EN
    ramp_limit_next = ramp_limit_reg;
`endif
    case (state_reg)
      DISARMED: begin
        // The synchronizer's post-reset zeros are not a genuine switch-low observation.
        if (!sw_s && sync_fill_reg[1]) seen_low_next = 1'b1;
        if (arm_cond) begin
          state_next    = ARMING;
          hold_next     = '0;
          seen_low_next = 1'b0;
        end
      end
      ARMING: begin
        if (!hold_ok) begin
          state_next = DISARMED;
        end else if (ms_tick) begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            state_next = ARMED;
            loss_next  = '0;
`ifdef ARM_SOFT_START_EN
            ramp_limit_next = '0;
`endif
          end
        end
      end
      ARMED: begin
        if (imu_s) loss_next = '0;
        else if (ms_tick) loss_next = loss_inc;
`ifdef ARM_SOFT_START_EN
        if (ms_tick) ramp_limit_next = ramp_sat;
`endif
        if (!imu_s && ms_tick && (loss_inc == LOSS_LAST)) state_next = FAULT;
        else if (!sw_s) state_next = DISARMED;
      end
      FAULT: begin
        if (!sw_s) begin
          state_next    = DISARMED;
          seen_low_next = 1'b1;
        end
      end
      default: state_next = DISARMED;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_reg    <= DISARMED;
      hold_reg     <= '0;
      loss_reg     <= '0;
      seen_low_reg <= 1'b0;
`ifdef ARM_SOFT_START_EN
      ramp_limit_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      loss_reg     <= loss_next;
      seen_low_reg <= seen_low_next;
`ifdef ARM_SOFT_START_EN
      ramp_limit_reg <= ramp_limit_next;
`endif
    end
  end

  assign rate_in[0] = motor_1_rate_in;
  assign rate_in[1] = motor_2_rate_in;
  assign rate_in[2] = motor_3_rate_in;
  assign rate_in[3] = motor_4_rate_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_motor
      // Outputs drop to zero on the same edge that leaves ARMED.
      always_comb begin
        rate_out_next[gi] = '0;
        if (state_reg == ARMED && state_next == ARMED) begin
`ifdef ARM_SOFT_START_EN
          rate_out_next[gi] = (rate_in[gi] < ramp_limit_reg) ? rate_in[gi] : ramp_limit_reg;
`else
          rate_out_next[gi] = rate_in[gi];
`endif
        end
      end

      always_ff @(posedge sys_clk) begin
        if (!resetn) rate_out_reg[gi] <= '0;
        else         rate_out_reg[gi] <= rate_out_next[gi];
      end
    end
  endgenerate

  assign motor_1_rate_out = rate_out_reg[0];
  assign motor_2_rate_out = rate_out_reg[1];
  assign motor_3_rate_out = rate_out_reg[2];
  assign motor_4_rate_out = rate_out_reg[3];
  assign armed = (state_reg == ARMED);
  assign fault = (state_reg == FAULT);
  assign state = state_reg;

endmodule

// File: tb/tb_motor_arm_sequencer.sv
// Scoreboard bench for motor_arm_sequencer: a millisecond-level model predicts state and gated rates,
// a monitor compares them at scheduled cycles.
module tb_motor_arm_sequencer;

  localparam int CPM = 10;

  logic        sys_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        arm_switch = 1'b1;
  logic        imu_good = 1'b1;
  logic [7:0]  throttle_val = 8'd0;
  logic [15:0] rin [4];
  logic [15:0] rout [4];
  logic        armed, fault;
  logic [1:0]  state;

  motor_arm_sequencer #(
    .RATE_W(16), .CLK_PER_MS(CPM), .ARM_HOLD_MS(4), .THR_ARM_MAX(8'd10),
    .IMU_LOSS_MS(3), .RAMP_STEP(16'h1000)
  ) dut (
    .sys_clk(sys_clk), .resetn(resetn), .arm_switch(arm_switch), .imu_good(imu_good),
    .throttle_val(throttle_val),
    .motor_1_rate_in(rin[0]), .motor_2_rate_in(rin[1]),
    .motor_3_rate_in(rin[2]), .motor_4_rate_in(rin[3]),
    .motor_1_rate_out(rout[0]), .motor_2_rate_out(rout[1]),
    .motor_3_rate_out(rout[2]), .motor_4_rate_out(rout[3]),
    .armed(armed), .fault(fault), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    int               st;
    logic [3:0][15:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Millisecond-level reference model.
  int m_st, m_seen, m_hold, m_loss, m_ramp;
  int seg_base, ms_k;
  bit cur_sw, cur_imu;

  task automatic chk(input string name, input int c, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, expv);
    end
  endtask

  always @(negedge sys_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_sample at cycle %0d: got none, expected sample at %0d", cyc, mon_e.cyc);
      end else begin
        chk("state", cyc, int'(state), mon_e.st);
        chk("armed", cyc, int'(armed), int'(mon_e.st == 2));
        chk("fault", cyc, int'(fault), int'(mon_e.st == 3));
        for (int i = 0; i < 4; i++)
          chk($sformatf("rate%0d", i + 1), cyc, int'(rout[i]), int'(mon_e.r[i]));
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no finish, expected end within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] exp_rate(input int st, input logic [15:0] v, input int ramp);
    logic [15:0] lim;
    lim = ramp[15:0];
    if (st != 2) return 16'h0;
`ifdef ARM_SOFT_START_EN
    return (v < lim) ? v : lim;
`else
    return (lim == lim) ? v : v;
`endif
  endfunction

  task automatic model_level(input bit sw, input bit imu, input int thr);
    bit ok;
    ok = sw && imu && (thr <= 10);
    case (m_st)
      0: begin
        if (!sw) m_seen = 1;
        else if (ok && m_seen == 1) begin m_st = 1; m_hold = 0; m_seen = 0; end
      end
      1: if (!ok) begin m_st = 0; if (!sw) m_seen = 1; end
      2: begin
        if (imu) m_loss = 0;
        if (!sw) begin m_st = 0; m_seen = 1; end
      end
      default: if (!sw) begin m_st = 0; m_seen = 1; end
    endcase
  endtask

  task automatic model_tick(input bit sw_t, input bit imu);
    case (m_st)
      0: if (!sw_t) m_seen = 1;
      1: begin
        if (!sw_t) begin m_st = 0; m_seen = 1; end
        else begin
          m_hold++;
          if (m_hold == 4) begin m_st = 2; m_ramp = 0; m_loss = 0; end
        end
      end
      2: begin
        m_ramp = (m_ramp + 4096 > 65535) ? 65535 : m_ramp + 4096;
        if (!imu) m_loss++;
        if (!imu && m_loss == 3) m_st = 3;
        else if (!sw_t) begin m_st = 0; m_seen = 1; end
      end
      default: if (!sw_t) begin m_st = 0; m_seen = 1; end
    endcase
  endtask

  task automatic push_exp(input int c, input int st, input logic [3:0][15:0] r);
    exp_t e;
    e.cyc = c;
    e.st  = st;
    e.r   = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One millisecond of stimulus; 'late' drops the switch so its synchronized edge lands on the ms tick.
  task automatic run_ms(input bit sw, input bit imu, input int thr, input logic [3:0][15:0] rv,
                        input bit late);
    int e0, pre_st, pre_ramp;
    logic [3:0][15:0] r;
    e0 = seg_base + CPM * ms_k;
    wait_edge(e0 + 1);
    arm_switch = sw;
    imu_good   = imu;
    wait_edge(e0 + 3);
    throttle_val = thr[7:0];
    for (int i = 0; i < 4; i++) rin[i] = rv[i];
    model_level(sw, imu, thr);
    for (int i = 0; i < 4; i++) r[i] = exp_rate(m_st, rv[i], m_ramp);
    push_exp(e0 + 4, m_st, r);
    push_exp(e0 + 9, m_st, r);
    $display("ms %0d: sw=%0b imu=%0b thr=%0d late=%0b expect state %0d", ms_k, sw, imu, thr, late, m_st);
    if (late) begin
      wait_edge(e0 + 7);
      arm_switch = 1'b0;
      pre_st   = m_st;
      pre_ramp = m_ramp;
      model_tick(1'b0, imu);
      for (int i = 0; i < 4; i++)
        r[i] = (pre_st == 2 && m_st == 2) ? exp_rate(2, rv[i], pre_ramp) : 16'h0;
      push_exp(e0 + 10, m_st, r);
    end else begin
      model_tick(sw, imu);
    end
    ms_k++;
  endtask

  task automatic ms_n(input int n, input bit sw, input bit imu, input int thr,
                      input logic [3:0][15:0] rv);
    for (int i = 0; i < n; i++) run_ms(sw, imu, thr, rv, 1'b0);
  endtask

  task automatic do_reset(input bit started);
    int c;
    logic [3:0][15:0] z;
    z = '0;
    if (started) wait_edge(seg_base + CPM * ms_k + 1);
    resetn     = 1'b0;
    arm_switch = 1'b1;
    imu_good   = 1'b1;
    throttle_val = 8'd0;
    c = cyc;
    for (int i = 1; i <= 3; i++) push_exp(c + i, 0, z);
    $display("reset asserted at cycle %0d", c);
    wait_edge(c + 3);
    resetn   = 1'b1;
    seg_base = cyc;
    ms_k     = 0;
    m_st = 0; m_seen = 0; m_hold = 0; m_loss = 0; m_ramp = 0;
  endtask

  task automatic rand_ms();
    logic [3:0][15:0] rv;
    int thr, sel;
    bit late;
    if ($urandom_range(24, 0) == 0) cur_sw = !cur_sw;
    if (cur_imu) cur_imu = ($urandom_range(14, 0) != 0);
    else         cur_imu = ($urandom_range(2, 0) == 0);
    sel = $urandom_range(9, 0);
    thr = (sel < 8) ? $urandom_range(10, 0) : (sel == 8) ? 11 : $urandom_range(255, 0);
    for (int i = 0; i < 4; i++) begin
      sel = $urandom_range(7, 0);
      rv[i] = (sel < 2) ? 16'hFFFF : (sel == 2) ? 16'h0 : 16'($urandom_range(65535, 0));
    end
    late = cur_sw && ($urandom_range(19, 0) == 0);
    run_ms(cur_sw, cur_imu, thr, rv, late);
    if (late) cur_sw = 1'b0;
  endtask

  initial begin
    logic [3:0][15:0] ff4, mixed, half4;
    ff4   = {4{16'hFFFF}};
    mixed = {16'hC000, 16'h0800, 16'h3456, 16'hFFFF};
    half4 = {4{16'h0800}};
    for (int i = 0; i < 4; i++) rin[i] = 16'h0;
    @(posedge sys_clk);
    #1;
    do_reset(1'b0);
    ms_n(3, 1, 1, 0, ff4);           // switch high through reset: no arming
    ms_n(1, 0, 1, 0, ff4);
    ms_n(4, 1, 1, 5, ff4);           // arm hold
    ms_n(20, 1, 1, 5, ff4);          // ramp to saturation
    ms_n(3, 1, 1, 5, mixed);
    ms_n(1, 1, 1, 5, half4);
    ms_n(1, 0, 1, 5, half4);         // switch drop zeroes within three cycles
    ms_n(2, 1, 1, 11, mixed);        // throttle just above limit
    ms_n(2, 1, 1, 10, mixed);        // throttle at limit: arming
    ms_n(1, 1, 1, 200, mixed);       // throttle raised mid-arming
    ms_n(3, 1, 1, 5, mixed);
    ms_n(1, 0, 1, 5, mixed);
    ms_n(7, 1, 1, 5, mixed);
    ms_n(2, 1, 0, 5, mixed);         // short IMU loss
    ms_n(3, 1, 1, 5, mixed);
    ms_n(3, 1, 0, 5, mixed);         // IMU loss limit
    ms_n(2, 1, 1, 5, mixed);
    ms_n(1, 0, 1, 5, mixed);
    ms_n(7, 1, 1, 5, mixed);
    ms_n(2, 1, 0, 5, mixed);
    run_ms(1, 0, 5, mixed, 1'b1);    // switch drop coincides with loss limit
    ms_n(2, 0, 1, 5, mixed);
    ms_n(7, 1, 1, 5, mixed);
    run_ms(1, 1, 5, mixed, 1'b1);    // switch drop on a tick without loss
    ms_n(1, 0, 1, 5, mixed);
    ms_n(7, 1, 1, 5, mixed);
    do_reset(1'b1);                  // reset while armed
    ms_n(3, 1, 1, 0, mixed);
    cur_sw  = 1'b0;
    cur_imu = 1'b1;
    for (int i = 0; i < 400; i++) rand_ms();
    wait_edge(seg_base + CPM * ms_k + 5);
    chk("queue_drained", cyc, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
